// File: rtl/gain_pkg.sv
// Shared types and helpers for the gain ramp stage.
package gain_pkg;

   // Working width for saturation; wide enough for any DATA_W+GAIN_W product.
   localparam int SAT_W = 64;

   typedef enum logic [1:0] {
      SETTLED,
      RAMP_UP,
      RAMP_DOWN
   } ramp_state_t;

   typedef struct packed {
      logic signed [SAT_W-1:0] value;
      logic                    clip;
   } sat_res_t;

   // Unity gain for a given number of fractional bits.
   function automatic int unity(input int frac_w);
      return 1 << frac_w;
   endfunction

   // Clamp a wide signed value into a data_w-bit signed range, flagging clips.
   function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] r,
                                          input int data_w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_res_t                res;
      hi = $signed((SAT_W'(1) << (data_w - 1)) - SAT_W'(1));
      lo = ~hi;
      res.value = r;
      res.clip  = 1'b0;
      if (r > hi) begin
         res.value = hi;
         res.clip  = 1'b1;
      end else if (r < lo) begin
         res.value = lo;
         res.clip  = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/gain_ramp_sat_mul.sv
// Two-stage valid-pipelined multiply, floor shift and saturate.
module gain_sat_mul
   import gain_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int GAIN_W = 16,
   parameter int FRAC_W = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_i,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic signed [GAIN_W-1:0] gain_i,
   output logic                     valid_o,
   output logic signed [DATA_W-1:0] sample_o,
   output logic                     sat_o
);

   localparam int P_W = DATA_W + GAIN_W;

   logic                     s1_valid_q;
   logic signed [DATA_W-1:0] s1_sample_q;
   logic signed [GAIN_W-1:0] s1_gain_q;
   logic signed [P_W-1:0]    prod;
   logic signed [P_W-1:0]    shifted;
   sat_res_t                 res;

   // Stage 1: capture sample with the gain in force when it was accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sample_q <= '0;
         s1_gain_q   <= '0;
      end else begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            s1_sample_q <= sample_i;
            s1_gain_q   <= gain_i;
         end
      end
   end

   // Full-width signed product, arithmetic shift (floor), then clamp.
   always_comb begin
      prod    = $signed({{GAIN_W{s1_sample_q[DATA_W-1]}}, s1_sample_q})
              * $signed({{DATA_W{s1_gain_q[GAIN_W-1]}}, s1_gain_q});
      shifted = prod >>> FRAC_W;
      res     = sat_trunc(SAT_W'(shifted), DATA_W);
   end

   // Stage 2: register scaled result and clip flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o  <= 1'b0;
         sample_o <= '0;
         sat_o    <= 1'b0;
      end else begin
         valid_o <= s1_valid_q;
         if (s1_valid_q) begin
            sample_o <= res.value[DATA_W-1:0];
            sat_o    <= res.clip;
         end
      end
   end

endmodule

// File: rtl/gain_ramp.sv
// Gain stage with zipper-free coefficient ramp and ramped mute.
//
// state     | meaning
// SETTLED   | cur_gain last reached the effective target
// RAMP_UP   | cur_gain stepping up toward the effective target
// RAMP_DOWN | cur_gain stepping down toward the effective target
module gain_ramp
   import gain_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int GAIN_W = 16,
   parameter int FRAC_W = 12,
   parameter int STEP   = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid_i,
   input  logic signed [DATA_W-1:0] in_sample_i,
   input  logic                     gain_we_i,
   input  logic signed [GAIN_W-1:0] gain_target_i,
   input  logic                     mute_i,
   output logic                     out_valid_o,
   output logic signed [DATA_W-1:0] out_sample_o,
   output logic signed [GAIN_W-1:0] cur_gain_o,
   output logic                     settled_o,
   output logic                     sat_o
);

   localparam logic signed [GAIN_W-1:0] UNITY_G = GAIN_W'(unity(FRAC_W));
   localparam logic signed [GAIN_W-1:0] STEP_G  = GAIN_W'(STEP);
   localparam logic signed [GAIN_W:0]   STEP_X  = (GAIN_W+1)'(STEP);

   logic signed [GAIN_W-1:0] target_q, target_d;
   logic signed [GAIN_W-1:0] cur_q, cur_d;
   logic signed [GAIN_W-1:0] eff;
   logic signed [GAIN_W-1:0] cur_up, cur_dn;
   logic signed [GAIN_W:0]   diff, diff_neg;
   ramp_state_t              state_q, state_d;
   ramp_state_t              st_up, st_dn;

   // Effective target and candidate up/down steps; one extra bit avoids wrap.
   always_comb begin
      eff      = mute_i ? '0 : target_q;
      diff     = {eff[GAIN_W-1], eff} - {cur_q[GAIN_W-1], cur_q};
      diff_neg = -diff;
      cur_up   = (diff <= STEP_X) ? eff : cur_q + STEP_G;
      st_up    = (diff <= STEP_X) ? SETTLED : RAMP_UP;
      cur_dn   = (diff_neg <= STEP_X) ? eff : cur_q - STEP_G;
      st_dn    = (diff_neg <= STEP_X) ? SETTLED : RAMP_DOWN;
   end

   // Ramp FSM next state; moves only on accepted samples so direction can flip.
   always_comb begin
      target_d = gain_we_i ? gain_target_i : target_q;
      state_d  = state_q;
      cur_d    = cur_q;
      if (in_valid_i) begin
         unique case (state_q)
            SETTLED: begin
               if (diff > 0) begin
                  cur_d = cur_up; state_d = st_up;
               end else if (diff < 0) begin
                  cur_d = cur_dn; state_d = st_dn;
               end
            end
            RAMP_UP: begin
               if (diff < 0) begin
                  cur_d = cur_dn; state_d = st_dn;
               end else if (diff > 0) begin
                  cur_d = cur_up; state_d = st_up;
               end else begin
                  state_d = SETTLED;
               end
            end
            RAMP_DOWN: begin
               if (diff > 0) begin
                  cur_d = cur_up; state_d = st_up;
               end else if (diff < 0) begin
                  cur_d = cur_dn; state_d = st_dn;
               end else begin
                  state_d = SETTLED;
               end
            end
            default: state_d = SETTLED;
         endcase
      end
   end

   // Target, current gain and ramp state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= UNITY_G;
         cur_q    <= UNITY_G;
         state_q  <= SETTLED;
      end else begin
         target_q <= target_d;
         cur_q    <= cur_d;
         state_q  <= state_d;
      end
   end

   assign cur_gain_o = cur_q;
   assign settled_o  = (cur_q == eff);

   gain_sat_mul #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W),
      .FRAC_W (FRAC_W)
   ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (in_valid_i),
      .sample_i (in_sample_i),
      .gain_i   (cur_q),
      .valid_o  (out_valid_o),
      .sample_o (out_sample_o),
      .sat_o    (sat_o)
   );

endmodule

// File: tb/tb_gain_ramp.sv
// Self-checking bench for gain_ramp against a plain arithmetic model.
module tb_gain_ramp;

   localparam int DW   = 16;
   localparam int GW   = 16;
   localparam int FW   = 12;
   localparam int STEP = 256;
   localparam int UNIT = 4096;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_sample = '0;
   logic                 gain_we = 1'b0;
   logic signed [GW-1:0] gain_target = '0;
   logic                 mute = 1'b0;
   logic                 out_valid;
   logic signed [DW-1:0] out_sample;
   logic signed [GW-1:0] cur_gain;
   logic                 settled;
   logic                 sat;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: current gain, stored target, mute level, two-deep output delay line.
   int m_cur, m_tgt;
   bit m_mute;
   bit pv[2];
   int ps[2];
   bit pt[2];

   gain_ramp #(.DATA_W(DW), .GAIN_W(GW), .FRAC_W(FW), .STEP(STEP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid_i    (in_valid),
      .in_sample_i   (in_sample),
      .gain_we_i     (gain_we),
      .gain_target_i (gain_target),
      .mute_i        (mute),
      .out_valid_o   (out_valid),
      .out_sample_o  (out_sample),
      .cur_gain_o    (cur_gain),
      .settled_o     (settled),
      .sat_o         (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cur = UNIT;
      m_tgt = UNIT;
      m_mute = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pv[i] = 1'b0; ps[i] = 0; pt[i] = 1'b0;
      end
   endtask

   // One clock: check outputs at the negedge, drive inputs, advance the model.
   task automatic cyc(input bit v, input int s, input bit we, input int tgt, input bit m);
      longint p, r;
      int     eff, y;
      bit     c;
      check("out_valid", out_valid, pv[1]);
      if (pv[1]) begin
         check("out_sample", out_sample, ps[1]);
         check("sat", sat, pt[1]);
      end
      check("cur_gain", cur_gain, m_cur);
      check("settled", settled, m_cur == (m_mute ? 0 : m_tgt));

      in_valid    = v;
      in_sample   = DW'(s);
      gain_we     = we;
      gain_target = GW'(tgt);
      mute        = m;
      m_mute      = m;

      pv[1] = pv[0]; ps[1] = ps[0]; pt[1] = pt[0];
      pv[0] = v;
      if (v) begin
         p = longint'(s) * longint'(m_cur);
         r = p >>> FW;
         c = 1'b0;
         if (r > 32767) begin y = 32767; c = 1'b1; end
         else if (r < -32768) begin y = -32768; c = 1'b1; end
         else y = int'(r);
         ps[0] = y; pt[0] = c;
         eff = m ? 0 : m_tgt;
         if (eff > m_cur) m_cur = (m_cur + STEP > eff) ? eff : m_cur + STEP;
         else if (eff < m_cur) m_cur = (m_cur - STEP < eff) ? eff : m_cur - STEP;
      end
      if (we) m_tgt = tgt;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit m);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, m);
   endtask

   initial begin
      int v, s, we, tgt;
      bit m;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_sample", out_sample, 0);
      check("rst_sat", sat, 0);
      check("rst_gain", cur_gain, UNIT);
      check("rst_settled", settled, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Unity pass-through with two-cycle latency
      cyc(1, 1000, 0, 0, 0);
      idle(3, 0);

      // Ramp to 2.0 over 16 accepted samples
      cyc(0, 0, 1, 8192, 0);
      check("t2_unsettled", settled, 0);
      for (int i = 0; i < 16; i++) cyc(1, 1000, 0, 0, 0);
      check("t2_gain", cur_gain, 8192);
      for (int i = 0; i < 4; i++) cyc(1, 1000, 0, 0, 0);
      idle(2, 0);

      // Saturation at gain 2.0
      cyc(1, 20000, 0, 0, 0);
      cyc(1, -20000, 0, 0, 0);
      cyc(1, 100, 0, 0, 0);
      idle(2, 0);

      // Floor rounding at gain 0.5
      cyc(0, 0, 1, 2048, 0);
      for (int i = 0; i < 30; i++) cyc(1, 7, 0, 0, 0);
      cyc(1, -3, 0, 0, 0);
      cyc(1, 3, 0, 0, 0);
      cyc(1, -1, 0, 0, 0);
      idle(2, 0);

      // Mute ramp down, release, and mid-ramp reversal
      cyc(0, 0, 1, UNIT, 0);
      for (int i = 0; i < 10; i++) cyc(1, 500, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1000, 0, 0, 1);
      check("t5_muted", cur_gain, 0);
      for (int i = 0; i < 8; i++) cyc(1, 1000, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1000, 0, 0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 1000, 0, 0, 0);
      cyc(1, 1000, 1, 12000, 1);
      for (int i = 0; i < 4; i++) cyc(1, 1000, 0, 0, 1);
      for (int i = 0; i < 40; i++) cyc(1, 1000, 0, 0, 0);

      // Reset mid-ramp with samples in flight
      cyc(0, 0, 1, -8000, 0);
      cyc(1, 1234, 0, 0, 0);
      cyc(1, -4321, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_sample", out_sample, 0);
      check("mid_rst_gain", cur_gain, UNIT);
      check("mid_rst_settled", settled, 1);
      model_reset();
      in_valid = 1'b0; gain_we = 1'b0; mute = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(4, 0);

      // Randomised traffic
      m = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
         s  = int'($urandom_range(0, 65535)) - 32768;
         we = ($urandom_range(0, 24) == 0) ? 1 : 0;
         if ($urandom_range(0, 1) == 0) tgt = int'($urandom_range(0, 65535)) - 32768;
         else tgt = int'($urandom_range(0, 3000)) - 1500;
         if ($urandom_range(0, 39) == 0) m = ~m;
         cyc(v[0], s, we[0], tgt, m);
      end
      idle(3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
